// File: rtl/ddr_burst_array.sv
// ddr_burst_array: behavioural DDR bank array with a command-driven burst engine.
//
// Purpose: per-bank open-row tracking, BL2/4/8 sequential or interleaved bursts,
// byte-masked writes and a CAS_LAT-deep read delay line. One beat per clk cycle.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   mode_bl, mode_bt         burst length code (1/2/3 -> 2/4/8) and burst type
//   act_valid/act_ba/act_ra  open a row in a bank
//   pre_valid/pre_ba         close a bank
//   cmd_valid/cmd_we/cmd_ba/cmd_ca  start a read or write burst
//   burst_stop               terminate the burst in progress
//   wr_data, wr_mask         write beat; mask bit 1 leaves that byte untouched
//   rd_data, rd_valid        read beat, registered, CAS_LAT after the array read
//   cmd_err                  one-cycle pulse for a rejected command
module ddr_burst_array #(
    parameter int unsigned NUM_BANKS = 4,
    parameter int unsigned ROW_WIDTH = 14,
    parameter int unsigned COL_WIDTH = 10,
    parameter int unsigned DW        = 16,
    parameter int unsigned CAS_LAT   = 2,
    localparam int unsigned BA_W     = $clog2(NUM_BANKS),
    localparam int unsigned MW       = DW / 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           mode_bl,
    input  logic                 mode_bt,
    input  logic                 act_valid,
    input  logic [BA_W-1:0]      act_ba,
    input  logic [ROW_WIDTH-1:0] act_ra,
    input  logic                 pre_valid,
    input  logic [BA_W-1:0]      pre_ba,
    input  logic                 cmd_valid,
    input  logic                 cmd_we,
    input  logic [BA_W-1:0]      cmd_ba,
    input  logic [COL_WIDTH-1:0] cmd_ca,
    input  logic                 burst_stop,
    input  logic [DW-1:0]        wr_data,
    input  logic [MW-1:0]        wr_mask,
    output logic [DW-1:0]        rd_data,
    output logic                 rd_valid,
    output logic                 cmd_err
);

    localparam int unsigned AW = BA_W + ROW_WIDTH + COL_WIDTH;

    typedef enum logic [1:0] {StIdle, StWr, StRd} state_e;

    // Burst engine state
    state_e               r_state;
    logic [BA_W-1:0]      r_ba;
    logic [ROW_WIDTH-1:0] r_brow;
    logic [COL_WIDTH-1:0] r_ca;
    logic [1:0]           r_k;      // log2(BL)
    logic                 r_bt;
    logic [2:0]           r_beat;   // index of the next beat to perform
    logic                 r_cmd_err;

    // Bank state and storage (storage is deliberately outside the reset domain)
    logic [NUM_BANKS-1:0] r_open;
    logic [ROW_WIDTH-1:0] r_row [NUM_BANKS];
    logic [DW-1:0]        r_mem [2**AW];

    // Read delay line; the last stage is the output register
    logic [CAS_LAT-1:0]   r_dl_vld;
    logic [DW-1:0]        r_dl_data [CAS_LAT];

    logic                 w_bl_legal;
    logic                 w_cmd_ok;
    logic                 w_stop;
    logic                 w_beat_en;
    logic                 w_beat_we;
    logic [BA_W-1:0]      w_ba;
    logic [ROW_WIDTH-1:0] w_row;
    logic [COL_WIDTH-1:0] w_ca;
    logic [1:0]           w_k;
    logic                 w_bt;
    logic [2:0]           w_idx;
    logic [COL_WIDTH-1:0] w_lowmask;
    logic [COL_WIDTH-1:0] w_low;
    logic [COL_WIDTH-1:0] w_col;
    logic                 w_last;
    logic [AW-1:0]        w_addr;
    logic [DW-1:0]        w_rd_word;
    logic [CAS_LAT-1:0]   w_dl_in_vld;
    logic [DW-1:0]        w_dl_in_data [CAS_LAT];

    assign w_bl_legal = (mode_bl == 3'd1) || (mode_bl == 3'd2) || (mode_bl == 3'd3);
    // Bank state is the registered one, so a same-cycle ACT does not make a command legal
    assign w_cmd_ok   = cmd_valid && w_bl_legal && r_open[cmd_ba];
    assign w_stop     = burst_stop || (pre_valid && (pre_ba == r_ba));

    // Select which beat (if any) is performed this cycle. A newly accepted command
    // performs its beat 0 in the command cycle and overrides any burst in progress.
    always_comb begin
        w_beat_en = 1'b0;
        w_beat_we = 1'b0;
        w_ba      = r_ba;
        w_row     = r_brow;
        w_ca      = r_ca;
        w_k       = r_k;
        w_bt      = r_bt;
        w_idx     = r_beat;
        if (w_cmd_ok) begin
            w_beat_en = 1'b1;
            w_beat_we = cmd_we;
            w_ba      = cmd_ba;
            w_row     = r_row[cmd_ba];
            w_ca      = cmd_ca;
            w_k       = mode_bl[1:0];
            w_bt      = mode_bt;
            w_idx     = 3'd0;
        end else if ((r_state != StIdle) && !w_stop) begin
            w_beat_en = 1'b1;
            w_beat_we = (r_state == StWr);
        end
    end

    // Beat column: upper bits fixed, low k bits wrap (sequential) or XOR (interleaved)
    always_comb begin
        case (w_k)
            2'd1:    w_lowmask = COL_WIDTH'(1);
            2'd2:    w_lowmask = COL_WIDTH'(3);
            default: w_lowmask = COL_WIDTH'(7);
        endcase
        w_low  = w_bt ? (w_ca ^ COL_WIDTH'(w_idx)) : (w_ca + COL_WIDTH'(w_idx));
        w_col  = (w_ca & ~w_lowmask) | (w_low & w_lowmask);
        w_last = (w_idx == w_lowmask[2:0]);
    end

    assign w_addr    = {w_ba, w_row, w_col};
    assign w_rd_word = r_mem[w_addr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= StIdle;
            r_ba      <= '0;
            r_brow    <= '0;
            r_ca      <= '0;
            r_k       <= 2'd1;
            r_bt      <= 1'b0;
            r_beat    <= 3'd0;
            r_cmd_err <= 1'b0;
        end else begin
            r_cmd_err <= cmd_valid && !w_cmd_ok;
            if (w_cmd_ok) begin
                r_state <= cmd_we ? StWr : StRd;
                r_ba    <= cmd_ba;
                r_brow  <= r_row[cmd_ba];
                r_ca    <= cmd_ca;
                r_k     <= mode_bl[1:0];
                r_bt    <= mode_bt;
                r_beat  <= 3'd1;
            end else if (r_state != StIdle) begin
                if (w_stop || w_last) begin
                    r_state <= StIdle;
                end else begin
                    r_beat <= r_beat + 3'd1;
                end
            end
        end
    end

    // PRE wins over ACT to the same bank; row is left alone in that case
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_open <= '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                r_row[b] <= '0;
            end
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (pre_valid && (pre_ba == BA_W'(b))) begin
                    r_open[b] <= 1'b0;
                end else if (act_valid && (act_ba == BA_W'(b))) begin
                    r_open[b] <= 1'b1;
                    r_row[b]  <= act_ra;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_beat_en && w_beat_we) begin
            for (int j = 0; j < MW; j++) begin
                if (!wr_mask[j]) begin
                    r_mem[w_addr][j*8 +: 8] <= wr_data[j*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        w_dl_in_vld     = '0;
        w_dl_in_vld[0]  = w_beat_en && !w_beat_we;
        w_dl_in_data[0] = w_rd_word;
        for (int i = 1; i < CAS_LAT; i++) begin
            w_dl_in_vld[i]  = r_dl_vld[i-1];
            w_dl_in_data[i] = r_dl_data[i-1];
        end
    end

    // Data only loads alongside a valid, so the output stage holds its last beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dl_vld <= '0;
            for (int i = 0; i < CAS_LAT; i++) begin
                r_dl_data[i] <= '0;
            end
        end else begin
            r_dl_vld <= w_dl_in_vld;
            for (int i = 0; i < CAS_LAT; i++) begin
                if (w_dl_in_vld[i]) begin
                    r_dl_data[i] <= w_dl_in_data[i];
                end
            end
        end
    end

    assign rd_valid = r_dl_vld[CAS_LAT-1];
    assign rd_data  = r_dl_data[CAS_LAT-1];
    assign cmd_err  = r_cmd_err;

endmodule

// File: tb/tb_ddr_burst_array.sv
// Testbench for ddr_burst_array: directed scenarios plus randomized traffic, checked
// against a transaction-level reference model through expectation queues.
module tb_ddr_burst_array;

    localparam int unsigned NB   = 4;
    localparam int unsigned RW   = 3;
    localparam int unsigned CW   = 5;
    localparam int unsigned DW   = 16;
    localparam int unsigned CL   = 2;
    localparam int unsigned BA_W = 2;
    localparam int unsigned MW   = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [2:0]    mode_bl = 3'd1;
    logic          mode_bt = 1'b0;
    logic          act_valid = 1'b0;
    logic [BA_W-1:0] act_ba = '0;
    logic [RW-1:0] act_ra = '0;
    logic          pre_valid = 1'b0;
    logic [BA_W-1:0] pre_ba = '0;
    logic          cmd_valid = 1'b0;
    logic          cmd_we = 1'b0;
    logic [BA_W-1:0] cmd_ba = '0;
    logic [CW-1:0] cmd_ca = '0;
    logic          burst_stop = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic [MW-1:0] wr_mask = '0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          cmd_err;

    ddr_burst_array #(
        .NUM_BANKS(NB),
        .ROW_WIDTH(RW),
        .COL_WIDTH(CW),
        .DW       (DW),
        .CAS_LAT  (CL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode_bl   (mode_bl),
        .mode_bt   (mode_bt),
        .act_valid (act_valid),
        .act_ba    (act_ba),
        .act_ra    (act_ra),
        .pre_valid (pre_valid),
        .pre_ba    (pre_ba),
        .cmd_valid (cmd_valid),
        .cmd_we    (cmd_we),
        .cmd_ba    (cmd_ba),
        .cmd_ca    (cmd_ca),
        .burst_stop(burst_stop),
        .wr_data   (wr_data),
        .wr_mask   (wr_mask),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .cmd_err   (cmd_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Reference model state
    typedef struct {
        int          cyc;
        logic [15:0] data;
        logic [15:0] known;
    } rd_exp_t;

    rd_exp_t     rd_q[$];
    int          err_q[$];
    logic [15:0] m_mem   [int];
    logic [15:0] m_known [int];
    bit          m_open  [NB];
    int          m_row   [NB];
    int          m_beats[$];
    bit          m_we;
    int          m_bank;
    logic [15:0] m_last = 16'h0;
    logic [15:0] m_last_known = 16'hFFFF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int addr_key(input int ba, input int row, input int col);
        return (ba << (RW + CW)) | (row << CW) | col;
    endfunction

    // Applies the spec rules to the inputs currently driven for this cycle
    task automatic model_eval();
        bit accepted;
        accepted = 0;
        if (cmd_valid) begin
            if (mode_bl >= 3'd1 && mode_bl <= 3'd3 && m_open[cmd_ba]) begin
                int bl;
                int off;
                int base;
                bl   = 1 << mode_bl;
                off  = int'(cmd_ca) % bl;
                base = int'(cmd_ca) - off;
                accepted = 1;
                m_beats.delete();
                m_we   = cmd_we;
                m_bank = int'(cmd_ba);
                for (int i = 0; i < bl; i++) begin
                    int col;
                    col = mode_bt ? base + (off ^ i) : base + ((off + i) % bl);
                    m_beats.push_back(addr_key(int'(cmd_ba), m_row[cmd_ba], col));
                end
            end else begin
                err_q.push_back(cyc + 1);
            end
        end
        if (!accepted && (burst_stop || (pre_valid && int'(pre_ba) == m_bank))) begin
            m_beats.delete();
        end
        if (m_beats.size() > 0) begin
            int a;
            a = m_beats.pop_front();
            if (!m_mem.exists(a)) begin
                m_mem[a]   = 16'h0;
                m_known[a] = 16'h0;
            end
            if (m_we) begin
                for (int j = 0; j < MW; j++) begin
                    if (!wr_mask[j]) begin
                        m_mem[a][j*8 +: 8]   = wr_data[j*8 +: 8];
                        m_known[a][j*8 +: 8] = 8'hFF;
                    end
                end
            end else begin
                rd_exp_t e;
                e.cyc   = cyc + CL;
                e.data  = m_mem[a];
                e.known = m_known[a];
                rd_q.push_back(e);
            end
        end
        for (int b = 0; b < NB; b++) begin
            if (pre_valid && int'(pre_ba) == b) begin
                m_open[b] = 0;
            end else if (act_valid && int'(act_ba) == b) begin
                m_open[b] = 1;
                m_row[b]  = int'(act_ra);
            end
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents an output
    always @(negedge clk) begin
        rd_exp_t e;
        if (rst) begin
            chk("reset_quiet", {30'h0, rd_valid, cmd_err}, 32'h0);
        end else begin
            if (rd_valid) begin
                if (rd_q.size() == 0) begin
                    chk("rd_unexpected", {31'h0, rd_valid}, 32'h0);
                end else begin
                    e = rd_q.pop_front();
                    chk("rd_cycle", cyc, e.cyc);
                    if (e.known != 16'h0) chk("rd_data", rd_data & e.known, e.data & e.known);
                    m_last       = e.data;
                    m_last_known = e.known;
                end
            end else begin
                if (rd_q.size() > 0 && rd_q[0].cyc <= cyc) begin
                    e = rd_q.pop_front();
                    chk("rd_missing", {31'h0, rd_valid}, 32'h1);
                end
                if (m_last_known != 16'h0) begin
                    chk("rd_hold", rd_data & m_last_known, m_last & m_last_known);
                end
            end
            if (cmd_err) begin
                if (err_q.size() == 0) chk("err_unexpected", {31'h0, cmd_err}, 32'h0);
                else chk("err_cycle", cyc, err_q.pop_front());
            end else if (err_q.size() > 0 && err_q[0] <= cyc) begin
                void'(err_q.pop_front());
                chk("err_missing", {31'h0, cmd_err}, 32'h1);
            end
        end
    end

    task automatic tick();
        model_eval();
        @(posedge clk);
        #1;
        act_valid  = 1'b0;
        pre_valid  = 1'b0;
        cmd_valid  = 1'b0;
        burst_stop = 1'b0;
        wr_data    = '0;
        wr_mask    = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        act_valid = 1'b0; pre_valid = 1'b0; cmd_valid = 1'b0; burst_stop = 1'b0;
        m_beats.delete();
        rd_q.delete();
        err_q.delete();
        for (int b = 0; b < NB; b++) m_open[b] = 0;
        m_last       = 16'h0;
        m_last_known = 16'hFFFF;
        #1;
        chk("rst_async_rd_valid", {31'h0, rd_valid}, 32'h0);
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic act(input int ba, input int ra);
        act_valid = 1'b1;
        act_ba    = BA_W'(ba);
        act_ra    = RW'(ra);
        tick();
    endtask

    // Write burst: beat i carries base+i; stop_at < 0 means no burst_stop
    task automatic wr_burst(input int ba, input int ca, input int blc, input bit bt,
                            input logic [15:0] base, input logic [1:0] m, input int stop_at);
        mode_bl   = 3'(blc);
        mode_bt   = bt;
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_ba    = BA_W'(ba);
        cmd_ca    = CW'(ca);
        for (int i = 0; i < (1 << blc); i++) begin
            wr_data = base + 16'(i);
            wr_mask = m;
            if (i == stop_at) burst_stop = 1'b1;
            tick();
        end
    endtask

    task automatic rd_burst(input int ba, input int ca, input int blc, input bit bt,
                            input int ncyc);
        mode_bl   = 3'(blc);
        mode_bt   = bt;
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_ba    = BA_W'(ba);
        cmd_ca    = CW'(ca);
        for (int i = 0; i < ncyc; i++) tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset(3);
        chk("reset_rd_data", {16'h0, rd_data}, 32'h0);
        chk("reset_rd_valid", {31'h0, rd_valid}, 32'h0);
        chk("reset_cmd_err", {31'h0, cmd_err}, 32'h0);

        // BL4 sequential write then wrapped read
        act(1, 5);
        wr_burst(1, 'h10, 2, 0, 16'h00A0, 2'b00, -1);
        rd_burst(1, 'h12, 2, 0, 4);
        idle(4);

        // BL8 interleaved write, BL8 sequential read
        wr_burst(1, 'h05, 3, 1, 16'h00D0, 2'b00, -1);
        rd_burst(1, 'h00, 3, 0, 8);
        idle(4);

        // Byte mask
        wr_burst(1, 'h08, 1, 0, 16'hFFFF, 2'b00, -1);
        wr_burst(1, 'h08, 1, 0, 16'h1234, 2'b10, -1);
        rd_burst(1, 'h08, 1, 0, 2);
        idle(4);

        // Gapless back-to-back reads, then an interrupted BL8 read
        act(3, 2);
        wr_burst(3, 'h00, 3, 0, 16'h3300, 2'b00, -1);
        rd_burst(1, 'h10, 2, 0, 4);
        rd_burst(1, 'h12, 2, 1, 4);
        rd_burst(1, 'h00, 3, 0, 3);
        rd_burst(3, 'h00, 3, 0, 8);
        idle(4);

        // Rejected commands: closed bank, illegal BL, same-cycle ACT
        rd_burst(2, 'h00, 2, 0, 1);
        wr_burst(1, 'h10, 0, 0, 16'hBAD0, 2'b00, -1);
        act_valid = 1'b1; act_ba = 2'd2; act_ra = 3'd1;
        rd_burst(2, 'h00, 2, 0, 2);
        rd_burst(1, 'h10, 2, 0, 4);
        idle(4);

        // burst_stop at beat 2 of a BL4 write
        wr_burst(1, 'h18, 2, 0, 16'h5550, 2'b00, -1);
        wr_burst(1, 'h18, 2, 0, 16'h7770, 2'b00, 2);
        rd_burst(1, 'h18, 2, 0, 4);
        idle(4);

        // Reset in the middle of a BL8 read; storage survives, bank closed
        rd_burst(1, 'h00, 3, 0, 3);
        do_reset(3);
        idle(2);
        rd_burst(1, 'h10, 2, 0, 2);
        act(1, 5);
        rd_burst(1, 'h10, 2, 0, 4);
        idle(4);

        // Randomized traffic
        for (int b = 0; b < NB; b++) act(b, b);
        for (int n = 0; n < 600; n++) begin
            act_valid  = ($urandom_range(0, 9) == 0);
            act_ba     = BA_W'($urandom_range(0, NB - 1));
            act_ra     = RW'($urandom_range(0, 3));
            pre_valid  = ($urandom_range(0, 39) == 0);
            pre_ba     = BA_W'($urandom_range(0, NB - 1));
            cmd_valid  = ($urandom_range(0, 4) == 0);
            cmd_we     = ($urandom_range(0, 1) == 1);
            cmd_ba     = BA_W'($urandom_range(0, NB - 1));
            cmd_ca     = CW'($urandom_range(0, 31));
            mode_bl    = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7))
                                                    : 3'($urandom_range(1, 3));
            mode_bt    = ($urandom_range(0, 1) == 1);
            burst_stop = ($urandom_range(0, 19) == 0);
            wr_data    = 16'($urandom);
            wr_mask    = ($urandom_range(0, 1) == 1) ? 2'($urandom_range(0, 3)) : 2'b00;
            tick();
        end
        idle(12);
        chk("rd_queue_drained", rd_q.size(), 32'h0);
        chk("err_queue_drained", err_q.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ddr_burst_array.md
# ddr_burst_array

Parametrised DDR bank-array behavioural model with a command-driven burst engine, configurable read latency and byte-masked writes. It sits behind the DDR command decoder and replaces the fixed 4-bank, 16-bit array. Bank count, data width and CAS latency are parameters. It adds per-bank open-row tracking, burst interruption, byte write masks and error flagging. One data beat is transferred per `clk` cycle; DDR edge doubling is handled upstream.

## Interface
- `NUM_BANKS`, 4, number of banks (power of two, ≥2); `BA_W = $clog2(NUM_BANKS)`
- `ROW_WIDTH`, 14, row address bits
- `COL_WIDTH`, 10, column address bits (≥3)
- `DW`, 16, data width (multiple of 8); `MW = DW/8`
- `CAS_LAT`, 2, read command-to-first-beat latency in cycles (1..7)

- `clk` in 1: single clock; all state updates on rising edge
- `rst` in 1: asynchronous, active-high reset
- `mode_bl` in 3: burst length code; 1→2, 2→4, 3→8, others illegal
- `mode_bt` in 1: 0 sequential, 1 interleaved
- `act_valid` in 1, `act_ba` in BA_W, `act_ra` in ROW_WIDTH: open row `act_ra` in bank `act_ba`
- `pre_valid` in 1, `pre_ba` in BA_W: close bank `pre_ba`
- `cmd_valid` in 1, `cmd_we` in 1, `cmd_ba` in BA_W, `cmd_ca` in COL_WIDTH: read (`cmd_we`=0) or write burst
- `burst_stop` in 1: terminate the current burst
- `wr_data` in DW, `wr_mask` in MW: write beat; mask bit 1 = byte NOT written
- `rd_data` out DW: read beat
- `rd_valid` out 1: `rd_data` valid
- `cmd_err` out 1: one-cycle pulse on a rejected command

## Operation
- Storage is `NUM_BANKS × 2^ROW_WIDTH × 2^COL_WIDTH × DW`, initialised to 0 at time zero. `rst` does NOT clear storage.
- Per bank, the block holds `open[b]` and `row[b]`. ACT sets both, and re-ACT of an open bank overwrites `row`. PRE clears `open`. ACT and PRE to the same bank in one cycle: PRE wins.
- BL is latched from `mode_bl` when a burst command is accepted, so mid-burst changes to `mode_bl`/`mode_bt` have no effect.
- Beat address for beat i (0..BL-1), with k = log2(BL): the upper column bits come from `cmd_ca[COL_WIDTH-1:k]`. The low k bits are `(ca[k-1:0]+i) mod BL` when sequential (wrap inside the block) and `ca[k-1:0] ^ i` when interleaved.
- Burst engine states:
  - IDLE: no burst in progress.
  - WR: burst state holds bank, row snapshot, start column, BL and beat counter. Each beat writes every byte whose `wr_mask` bit is 0.
  - RD: same burst state. Each beat reads storage and pushes it into a CAS_LAT-deep delay line.
- Accepted `cmd_valid` (bank open, BL legal) in any state starts a new burst at beat 0. Any burst in progress is truncated immediately, and read beats already in the delay line still emerge.
- Rejected command (bank closed or `mode_bl` illegal): `cmd_err`=1 next cycle, no state change, in-progress burst continues.
- A burst ends after beat BL-1 (→IDLE). It also ends on `burst_stop` or on PRE to the burst's bank; that cycle's beat is not performed.
- `cmd_valid` together with `burst_stop`: the new command is accepted and the stop is ignored.
- A write and a read of the same address in the same cycle: the read returns old data.

## Timing
- Reset values: `rd_data`=0, `rd_valid`=0, `cmd_err`=0. All banks closed, engine IDLE, delay line cleared.
- `rst` asserted mid-burst aborts the burst immediately; no further beats or `rd_valid` appear.
- Write: beat 0 uses `wr_data`/`wr_mask` sampled in the command cycle (T). Beat i is sampled at T+i.
- Read: the beat-i array read occurs at T+i. Beat i appears with `rd_valid`=1 at T+CAS_LAT+i, registered.
- Gapless back-to-back bursts: the next command at T+BL gives a continuous data stream with no idle cycle.
- ACT at T makes the bank usable by a command at T+1. A command in the same cycle as the ACT to the same bank is rejected.
- `cmd_err` pulses exactly one cycle, at T+1.
- `rd_data` holds its last value while `rd_valid`=0.

## Test plan
- Reset → ACT b1 row 5 → WR ca=0x10, BL4 seq, data A0..A3, mask 0 → RD ca=0x12 with CAS_LAT=2 → `rd_valid` at T+2..T+5 with data A2,A3,A0,A1.
- BL8 interleaved WR ca=0x05, data D0..D7 → BL8 seq RD ca=0x00 → readback order D5,D4,D7,D6,D1,D0,D3,D2.
- WR 0xFFFF to an address, then WR 0x1234 with `wr_mask`=2'b10 to the same address → RD returns 0xFF34.
- RD BL8 interrupted at beat 3 by RD on another open bank → exactly 3 beats of the first burst, then 8 beats of the second, contiguous.
- RD to closed bank b2, and WR with `mode_bl`=0 → `cmd_err` one-cycle pulse each, no `rd_valid`, storage unchanged. `burst_stop` at beat 2 of a BL4 WR → beats 2,3 not written.
- `rst` asserted during a BL8 read → `rd_valid`=0 from reset onward. After release, the previously active bank is closed and data written before reset is still readable after re-ACT.
